alu_arbiter: RTL

Shares one combinational ALU instance between NREQ requesters, for example the execute stage and the address/branch-compare path. Each request carries an op, alt flag, two operands and a tag. Each requester has a valid/ready request channel and its own valid/ready response channel. The block arbitrates round-robin, sanitises shift operands, drives the shared ALU, and registers each result into a one-entry response slot per requester.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/alu.sv | 33 +++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/alu_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V ALU encodings and the request bundle that feeds the shared ALU.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package riscv_pkg;

    // funct3 encodings for the integer ALU (OP / OP-IMM)
    localparam logic [2:0] F3_ALU_ADD  = 3'b000;  // ADD / SUB (alt)
    localparam logic [2:0] F3_ALU_SLL  = 3'b001;
    localparam logic [2:0] F3_ALU_SLT  = 3'b010;
    localparam logic [2:0] F3_ALU_SLTU = 3'b011;
    localparam logic [2:0] F3_ALU_XOR  = 3'b100;
    localparam logic [2:0] F3_ALU_SR   = 3'b101;  // SRL / SRA (alt)
    localparam logic [2:0] F3_ALU_OR   = 3'b110;
    localparam logic [2:0] F3_ALU_AND  = 3'b111;

    // One ALU operation. The tag travels separately because its width is a
    // parameter of whichever block carries it.
    typedef struct packed {
        logic [2:0]  op;
        logic        alt;
        logic [31:0] operand1;
        logic [31:0] operand2;
    } alu_req_t;

    // Clean up a request before it reaches the ALU: shift amounts keep only
    // their low five bits, and alt survives only where it selects SUB or SRA.
    function automatic alu_req_t alu_sanitise(input alu_req_t r);
        alu_req_t s;
        s = r;
        if (r.op == F3_ALU_SLL || r.op == F3_ALU_SR) begin
            s.operand2 = {27'd0, r.operand2[4:0]};
        end
        if (r.op != F3_ALU_ADD && r.op != F3_ALU_SR) begin
            s.alt = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational RV32I integer ALU.
// Latency: 0 cycles. Backpressure: none (no state).
// Ports: op_i (funct3), alt_i (SUB/SRA select), operand1_i, operand2_i, result_o.
module alu
    import riscv_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic        alt_i,
    input  logic [31:0] operand1_i,
    input  logic [31:0] operand2_i,
    output logic [31:0] result_o
);

    logic [4:0] shamt;
    assign shamt = operand2_i[4:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            F3_ALU_ADD:  result_o = alt_i ? (operand1_i - operand2_i) : (operand1_i + operand2_i);
            F3_ALU_SLL:  result_o = operand1_i << shamt;
            F3_ALU_SLT:  result_o = {31'd0, $signed(operand1_i) < $signed(operand2_i)};
            F3_ALU_SLTU: result_o = {31'd0, operand1_i < operand2_i};
            F3_ALU_XOR:  result_o = operand1_i ^ operand2_i;
            F3_ALU_SR:   result_o = alt_i ? $unsigned($signed(operand1_i) >>> shamt)
                                          : (operand1_i >> shamt);
            F3_ALU_OR:   result_o = operand1_i | operand2_i;
            F3_ALU_AND:  result_o = operand1_i & operand2_i;
            default:     result_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant plus a priority pointer.
// Latency: grant is combinational from req_i; pointer moves on the next edge.
// Backpressure: callers gate req_i; any grant is assumed to be taken.
// Ports: clk_i, rst_i (async, active-high), req_i[N], gnt_o[N] (one-hot or zero).
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;

    // Search upward from rr_ptr with wrap; the first requester hit wins.
    always_comb begin
        logic [PTR_W:0]   pos;
        logic [PTR_W-1:0] idx;
        gnt_o   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(N)) begin
                pos = pos - (PTR_W+1)'(N);
            end
            idx = pos[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

    // Winner drops to lowest priority: pointer moves just past it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= (gnt_idx == PTR_W'(N-1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters; one registered result slot each.
// Latency: accept in cycle N -> rsp_valid_o in cycle N+1; one op per cycle overall.
// Backpressure: a requester whose slot is full and not draining is masked from arbitration.
// Ports: per-requester req_* valid/ready channel (op, alt, operands, tag),
//        per-requester rsp_* valid/ready channel (result, tag), grant_count_o counters.
module alu_arbiter
    import riscv_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NREQ-1:0]             req_valid_i,
    output logic [NREQ-1:0]             req_ready_o,
    input  logic [NREQ-1:0][2:0]        req_op_i,
    input  logic [NREQ-1:0]             req_alt_i,
    input  logic [NREQ-1:0][31:0]       req_operand1_i,
    input  logic [NREQ-1:0][31:0]       req_operand2_i,
    input  logic [NREQ-1:0][TAG_W-1:0]  req_tag_i,
    output logic [NREQ-1:0]             rsp_valid_o,
    input  logic [NREQ-1:0]             rsp_ready_i,
    output logic [NREQ-1:0][31:0]       rsp_result_o,
    output logic [NREQ-1:0][TAG_W-1:0]  rsp_tag_o,
    output logic [NREQ-1:0][15:0]       grant_count_o
);

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt;
    alu_req_t        sel_req;
    alu_req_t        alu_in;
    logic [31:0]     alu_result;

    // A slot that drains this cycle can take a new result in the same cycle.
    // Eligibility is also killed during reset so nothing is accepted then.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = !rst_i && req_valid_i[i] && (!rsp_valid_o[i] || rsp_ready_i[i]);
        end
    end

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (eligible),
        .gnt_o (gnt)
    );

    assign req_ready_o = gnt;

    // Grant is one-hot (or zero), so an AND-OR mux picks the winner's request.
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_req.op       = sel_req.op       | req_op_i[i];
                sel_req.alt      = sel_req.alt      | req_alt_i[i];
                sel_req.operand1 = sel_req.operand1 | req_operand1_i[i];
                sel_req.operand2 = sel_req.operand2 | req_operand2_i[i];
            end
        end
        alu_in = alu_sanitise(sel_req);
    end

    alu u_alu (
        .op_i       (alu_in.op),
        .alt_i      (alu_in.alt),
        .operand1_i (alu_in.operand1),
        .operand2_i (alu_in.operand2),
        .result_o   (alu_result)
    );

    // Response slots. Only the granted slot captures the shared ALU result;
    // the tag comes straight from that requester.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_o   <= '0;
            rsp_result_o  <= '0;
            rsp_tag_o     <= '0;
            grant_count_o <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    rsp_valid_o[i]   <= 1'b1;
                    rsp_result_o[i]  <= alu_result;
                    rsp_tag_o[i]     <= req_tag_i[i];
                    grant_count_o[i] <= grant_count_o[i] + 16'd1;
                end else if (rsp_ready_i[i]) begin
                    rsp_valid_o[i] <= 1'b0;
                end
            end
        end
    end

endmodule
